// File: rtl/im2col_router.sv
`timescale 1ns/1ps
// im2col_router: walks a KxK window for ROW_COUNT output pixels per group and emits one ROW_COUNT-wide beat per tap.
// Latency: first o_valid ROW_COUNT+2 cycles after i_en; one beat every ROW_COUNT+2 cycles with i_ready held high.
// Backpressure: EMIT holds o_valid/o_data/o_row_mask stable until i_ready; no reads issue while stalled.
// Optional build macro IM2COL_ROUTER_SKEW_EN: per-row systolic skew delay lines plus ROW_COUNT-1 flush beats.
module im2col_router #(
    parameter int ROW_COUNT   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DIM_WIDTH   = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_en,
    input  logic                            i_reg_clear,
    input  logic [ADDR_WIDTH-1:0]           i_start_addr,
    input  logic [DIM_WIDTH-1:0]            i_i_size,
    input  logic [DIM_WIDTH-1:0]            i_o_size,
    input  logic [DIM_WIDTH-1:0]            i_stride,
    output logic                            o_mem_read_en,
    output logic [ADDR_WIDTH-1:0]           o_mem_read_addr,
    input  logic [DATA_WIDTH-1:0]           i_mem_data,
    output logic [ROW_COUNT*DATA_WIDTH-1:0] o_data,
    output logic [ROW_COUNT-1:0]            o_row_mask,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int PW = 2 * DIM_WIDTH + 1;
    localparam int RW = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_COUNT - 1);
    localparam logic [KW-1:0] TAP_LAST = KW'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_EMIT, S_DONE} state_t;
    state_t state_q, state_d;

    // Job configuration, latched on the start cycle.
    logic [ADDR_WIDTH-1:0] start_q;
    logic [DIM_WIDTH-1:0]  isize_q, osize_q, stride_q;
    logic [PW-1:0]         ptot_q;
    // Group base coordinates (row 0) and the per-row walking coordinates.
    logic [DIM_WIDTH-1:0]  gx_q, gy_q, rx_q, ry_q;
    logic [PW-1:0]         gp_q, rp_q;
    logic [RW-1:0]         row_q, pend_row_q;
    logic                  pend_q;
    logic [KW-1:0]         kx_q, ky_q;
    logic [DATA_WIDTH-1:0] data_q [ROW_COUNT];
    logic [ROW_COUNT-1:0]  mask_q;

    logic row_live_c, last_tap_c, final_grp_c, last_real_c, flush_c, start_c;
    logic [ADDR_WIDTH-1:0] iy_c, ix_c, addr_c;
    logic [ROW_COUNT*DATA_WIDTH-1:0] beat_dat_c;

`ifdef IM2COL_ROUTER_SKEW_EN
    localparam int HD = (ROW_COUNT > 1) ? ROW_COUNT - 1 : 1;
    localparam logic [RW-1:0] FLUSH_LAST = RW'((ROW_COUNT > 1) ? ROW_COUNT - 2 : 0);
    logic [ROW_COUNT*DATA_WIDTH-1:0] hist_dat_q [HD];
    logic [ROW_COUNT-1:0]            hist_msk_q [HD];
    logic                            flush_q;
    logic [RW-1:0]                   flush_cnt_q;
    assign flush_c = flush_q;
`else
    assign flush_c = 1'b0;
`endif

    assign start_c     = (state_q == S_IDLE) && i_en;
    assign row_live_c  = (rp_q < ptot_q);
    assign last_tap_c  = (kx_q == TAP_LAST) && (ky_q == TAP_LAST);
    // After a full fetch rp_q already points at the next group's first pixel.
    assign final_grp_c = (rp_q >= ptot_q);
    assign last_real_c = last_tap_c && final_grp_c && !flush_c;

    // Element address from the current row coordinates and kernel tap (mod 2^ADDR_WIDTH).
    always_comb begin
        iy_c   = ADDR_WIDTH'(ry_q) * ADDR_WIDTH'(stride_q) + ADDR_WIDTH'(ky_q);
        ix_c   = ADDR_WIDTH'(rx_q) * ADDR_WIDTH'(stride_q) + ADDR_WIDTH'(kx_q);
        addr_c = start_q + iy_c * ADDR_WIDTH'(isize_q) + ix_c;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; clear overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (i_en) state_d = (i_o_size == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (row_q == ROW_LAST) state_d = S_LAST;
            S_LAST:  state_d = S_EMIT;
            S_EMIT: if (i_ready) begin
`ifdef IM2COL_ROUTER_SKEW_EN
                if (flush_q)          state_d = (flush_cnt_q == FLUSH_LAST) ? S_DONE : S_EMIT;
                else if (last_real_c) state_d = (ROW_COUNT > 1) ? S_EMIT : S_DONE;
                else                  state_d = S_FETCH;
`else
                state_d = last_real_c ? S_DONE : S_FETCH;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_reg_clear) state_d = S_IDLE;
    end

    // Config latch and incremental pixel/tap walk (no divider: coordinates step with wrap).
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            start_q <= '0; isize_q <= '0; osize_q <= '0; stride_q <= '0; ptot_q <= '0;
            gx_q <= '0; gy_q <= '0; gp_q <= '0; rx_q <= '0; ry_q <= '0; rp_q <= '0;
            row_q <= '0; kx_q <= '0; ky_q <= '0;
        end else if (i_reg_clear || start_c) begin
            start_q  <= i_reg_clear ? '0 : i_start_addr;
            isize_q  <= i_reg_clear ? '0 : i_i_size;
            osize_q  <= i_reg_clear ? '0 : i_o_size;
            stride_q <= i_reg_clear ? '0 : i_stride;
            ptot_q   <= i_reg_clear ? '0 : PW'(i_o_size) * PW'(i_o_size);
            gx_q <= '0; gy_q <= '0; gp_q <= '0; rx_q <= '0; ry_q <= '0; rp_q <= '0;
            row_q <= '0; kx_q <= '0; ky_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (rx_q == osize_q - DIM_WIDTH'(1)) begin
                        rx_q <= '0;
                        ry_q <= ry_q + DIM_WIDTH'(1);
                    end else begin
                        rx_q <= rx_q + DIM_WIDTH'(1);
                    end
                    rp_q  <= rp_q + PW'(1);
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                end
                S_EMIT: if (i_ready && !flush_c) begin
                    if (!last_tap_c) begin
                        if (kx_q == TAP_LAST) begin
                            kx_q <= '0;
                            ky_q <= ky_q + KW'(1);
                        end else begin
                            kx_q <= kx_q + KW'(1);
                        end
                        rx_q <= gx_q; ry_q <= gy_q; rp_q <= gp_q;
                    end else begin
                        kx_q <= '0; ky_q <= '0;
                        gx_q <= rx_q; gy_q <= ry_q; gp_q <= rp_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat assembly: mark live rows, zero dead rows, capture read data one cycle after the strobe.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pend_q <= 1'b0; pend_row_q <= '0; mask_q <= '0;
            for (int r = 0; r < ROW_COUNT; r++) data_q[r] <= '0;
        end else if (i_reg_clear) begin
            pend_q <= 1'b0; pend_row_q <= '0; mask_q <= '0;
            for (int r = 0; r < ROW_COUNT; r++) data_q[r] <= '0;
        end else begin
            pend_q     <= (state_q == S_FETCH) && row_live_c;
            pend_row_q <= row_q;
            if (state_q == S_FETCH) begin
                mask_q[row_q] <= row_live_c;
                if (!row_live_c) data_q[row_q] <= '0;
            end
            if (pend_q) data_q[pend_row_q] <= i_mem_data;
`ifdef IM2COL_ROUTER_SKEW_EN
            // Flush beats feed zeros into the delay lines.
            if (state_q == S_EMIT && i_ready && last_real_c) begin
                mask_q <= '0;
                for (int r = 0; r < ROW_COUNT; r++) data_q[r] <= '0;
            end
`endif
        end
    end

    // Pack the assembled beat.
    always_comb begin
        beat_dat_c = '0;
        for (int r = 0; r < ROW_COUNT; r++) beat_dat_c[r*DATA_WIDTH +: DATA_WIDTH] = data_q[r];
    end

`ifdef IM2COL_ROUTER_SKEW_EN
    // Beat history shifted on each accepted beat; row r reads the entry r beats old.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            flush_q <= 1'b0; flush_cnt_q <= '0;
            for (int d = 0; d < HD; d++) begin hist_dat_q[d] <= '0; hist_msk_q[d] <= '0; end
        end else if (i_reg_clear || start_c) begin
            flush_q <= 1'b0; flush_cnt_q <= '0;
            for (int d = 0; d < HD; d++) begin hist_dat_q[d] <= '0; hist_msk_q[d] <= '0; end
        end else if (state_q == S_EMIT && i_ready) begin
            hist_dat_q[0] <= beat_dat_c;
            hist_msk_q[0] <= mask_q;
            for (int d = 1; d < HD; d++) begin
                hist_dat_q[d] <= hist_dat_q[d-1];
                hist_msk_q[d] <= hist_msk_q[d-1];
            end
            if (flush_q)          flush_cnt_q <= flush_cnt_q + RW'(1);
            else if (last_real_c) begin flush_q <= 1'b1; flush_cnt_q <= '0; end
        end
    end
`endif

    // Output beat: only driven in EMIT, zero elsewhere.
    always_comb begin
        o_data     = '0;
        o_row_mask = '0;
        if (state_q == S_EMIT) begin
`ifdef IM2COL_ROUTER_SKEW_EN
            o_data[0 +: DATA_WIDTH] = data_q[0];
            o_row_mask[0]           = mask_q[0];
            for (int r = 1; r < ROW_COUNT; r++) begin
                o_data[r*DATA_WIDTH +: DATA_WIDTH] = hist_dat_q[(r > 0) ? r - 1 : 0][r*DATA_WIDTH +: DATA_WIDTH];
                o_row_mask[r]                      = hist_msk_q[(r > 0) ? r - 1 : 0][r];
            end
`else
            o_data     = beat_dat_c;
            o_row_mask = mask_q;
`endif
        end
    end

    assign o_mem_read_en   = (state_q == S_FETCH) && row_live_c;
    assign o_mem_read_addr = o_mem_read_en ? addr_c : '0;
    assign o_valid         = (state_q == S_EMIT);
    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = (state_q == S_DONE);

endmodule

// File: tb/tb_im2col_router.sv
`timescale 1ns/1ps
// tb_im2col_router: directed jobs with a queue scoreboard and an independent output monitor.
// Memory model returns mem[a] = a one cycle after each read strobe.
// Expected beats come from a direct div/mod formula of the convolution window.
module tb_im2col_router;
    localparam int R  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [R*DW-1:0] dat;
        logic [R-1:0]    msk;
    } beat_t;

    logic          i_clk = 1'b0;
    logic          i_nrst, i_en, i_reg_clear, i_ready;
    logic [7:0]    i_start_addr, i_i_size, i_o_size, i_stride;
    logic          o_mem_read_en;
    logic [7:0]    o_mem_read_addr;
    logic [7:0]    i_mem_data;
    logic [R*DW-1:0] o_data;
    logic [R-1:0]  o_row_mask;
    logic          o_valid, o_busy, o_done;

    im2col_router #(.ROW_COUNT(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .DIM_WIDTH(8), .KERNEL_SIZE(3)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_en(i_en), .i_reg_clear(i_reg_clear),
        .i_start_addr(i_start_addr), .i_i_size(i_i_size), .i_o_size(i_o_size), .i_stride(i_stride),
        .o_mem_read_en(o_mem_read_en), .o_mem_read_addr(o_mem_read_addr), .i_mem_data(i_mem_data),
        .o_data(o_data), .o_row_mask(o_row_mask), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial forever #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_mem_read_en) i_mem_data <= o_mem_read_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nacc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_acc_cyc = 0;
    logic [R*DW-1:0] recv_dat [64];
    logic [R-1:0]    recv_msk [64];
    int              rd_per   [64];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every accepted beat.
    initial forever begin
        @(negedge i_clk);
        if (i_nrst) begin
            if (o_mem_read_en) rd_cnt++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got data 0x%0h mask 0x%0h with nothing expected", o_data, o_row_mask);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", nacc), {o_data, o_row_mask}, {e.dat, e.msk});
                end
                if (nacc < 64) begin
                    recv_dat[nacc] = o_data;
                    recv_msk[nacc] = o_row_mask;
                    rd_per[nacc]   = rd_cnt;
                end
                rd_cnt = 0;
                nacc++;
                last_acc_cyc = cyc;
            end
        end
    end

    // Reference: direct formula for each tap/row, then optional skew.
    task automatic push_job(input int st, input int is, input int os, input int sd, output int n);
        int P, G, nr;
        beat_t real_q[$];
        beat_t b;
        P = os * os;
        G = (P + R - 1) / R;
        for (int g = 0; g < G; g++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++) begin
                    b = '0;
                    for (int r = 0; r < R; r++) begin
                        int p, ox, oy, a;
                        p = g * R + r;
                        if (p < P) begin
                            ox = p % os;
                            oy = p / os;
                            a  = (st + (oy * sd + ky) * is + ox * sd + kx) % 256;
                            b.dat[r*DW +: DW] = a[7:0];
                            b.msk[r] = 1'b1;
                        end
                    end
                    real_q.push_back(b);
                end
        nr = real_q.size();
`ifdef IM2COL_ROUTER_SKEW_EN
        n = (nr == 0) ? 0 : nr + R - 1;
        for (int t = 0; t < n; t++) begin
            b = '0;
            for (int r = 0; r < R; r++) begin
                if (t - r >= 0 && t - r < nr) begin
                    b.dat[r*DW +: DW] = real_q[t-r].dat[r*DW +: DW];
                    b.msk[r] = real_q[t-r].msk[r];
                end
            end
            exp_q.push_back(b);
        end
`else
        n = nr;
        foreach (real_q[i]) exp_q.push_back(real_q[i]);
`endif
    endtask

    task automatic run_job(input string nm, input int st, input int is, input int os, input int sd,
                           input bit bp, input bit lat);
        int n, c, first_c, d0;
        bit stall_done, ok;
        logic [R*DW-1:0] snap_d;
        logic [R-1:0] snap_m;
        exp_q.delete();
        push_job(st, is, os, sd, n);
        nacc = 0;
        rd_cnt = 0;
        i_start_addr = st[7:0]; i_i_size = is[7:0]; i_o_size = os[7:0]; i_stride = sd[7:0];
        i_en = 1'b1;
        @(posedge i_clk); #1;
        i_en = 1'b0;
        d0 = done_cnt; first_c = 0; c = 1; stall_done = 1'b0;
        while (done_cnt == d0 && c < 3000) begin
            if (o_valid && first_c == 0) first_c = c;
            if (bp && !stall_done && o_valid && nacc == 3) begin
                snap_d = o_data; snap_m = o_row_mask; ok = 1'b1;
                i_ready = 1'b0;
                repeat (5) begin
                    @(posedge i_clk); #1; c++;
                    if (!(o_valid && o_data == snap_d && o_row_mask == snap_m && !o_mem_read_en)) ok = 1'b0;
                end
                chk({nm, "_stall_hold"}, ok, 1);
                i_ready = 1'b1;
                stall_done = 1'b1;
            end
            @(posedge i_clk); #1; c++;
        end
        chk({nm, "_done_seen"}, (done_cnt != d0), 1);
        if (lat) chk({nm, "_first_valid_cycle"}, first_c, 6);
        chk({nm, "_beat_count"}, nacc, n);
        chk({nm, "_scoreboard_left"}, exp_q.size(), 0);
        if (n > 0) chk({nm, "_done_after_last"}, done_cyc, last_acc_cyc + 1);
        chk({nm, "_idle_after_done"}, {o_busy, o_done}, 0);
    endtask

    initial begin
        int d0, c;
        i_nrst = 1'b0; i_en = 1'b0; i_reg_clear = 1'b0; i_ready = 1'b1;
        i_start_addr = '0; i_i_size = '0; i_o_size = '0; i_stride = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_valid_busy_done", {o_valid, o_busy, o_done}, 0);
        chk("reset_read", {o_mem_read_en, o_mem_read_addr}, 0);
        chk("reset_data_mask", {o_data, o_row_mask}, 0);
        #2 i_nrst = 1'b1;
        @(posedge i_clk); #1;

        run_job("basic", 0, 4, 2, 1, 0, 1);
`ifdef IM2COL_ROUTER_SKEW_EN
        chk("skew_count", nacc, 12);
        chk("skew_b0", {recv_dat[0], recv_msk[0]}, {32'h0, 4'b0001});
        chk("skew_b1_row1", recv_dat[1][15:8], 1);
        chk("skew_b11_row3", {recv_dat[11][31:24], recv_msk[11]}, {8'd15, 4'b1000});
`else
        chk("basic_count", nacc, 9);
        chk("basic_b0", {recv_dat[0], recv_msk[0]}, {32'h05040100, 4'hF});
        chk("basic_b8", {recv_dat[8], recv_msk[8]}, {32'h0F0E0B0A, 4'hF});
        chk("basic_b0_reads", rd_per[0], 4);
`endif

        run_job("stride", 0, 5, 2, 2, 0, 1);
`ifndef IM2COL_ROUTER_SKEW_EN
        chk("stride_b4", {recv_dat[4], recv_msk[4]}, {32'h12100806, 4'hF});
`endif

        run_job("tail", 0, 5, 3, 1, 0, 1);
        chk("tail_g2_reads", rd_per[18], 1);
`ifndef IM2COL_ROUTER_SKEW_EN
        chk("tail_count", nacc, 27);
        chk("tail_g2_b0", {recv_dat[18], recv_msk[18]}, {32'h0000000C, 4'b0001});
`endif

        run_job("backpressure", 0, 4, 2, 1, 1, 1);
        chk("bp_b3_reads", rd_per[3], 4);

        run_job("wrap", 250, 6, 3, 1, 0, 1);

        // Asynchronous reset during FETCH.
        i_start_addr = 8'd0; i_i_size = 8'd4; i_o_size = 8'd2; i_stride = 8'd1;
        i_en = 1'b1;
        @(posedge i_clk); #1;
        i_en = 1'b0;
        @(posedge i_clk); #1;
        chk("midfetch_reading", {o_busy, o_mem_read_en}, 2'b11);
        #2 i_nrst = 1'b0;
        #1;
        chk("async_reset_outputs", {o_valid, o_busy, o_done, o_mem_read_en, o_mem_read_addr, o_data, o_row_mask}, 0);
        d0 = done_cnt;
        repeat (2) @(posedge i_clk);
        #2 i_nrst = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_idle", o_busy, 0);

        // Synchronous clear while a beat is stalled in EMIT.
        i_ready = 1'b0;
        i_en = 1'b1;
        @(posedge i_clk); #1;
        i_en = 1'b0;
        c = 0;
        while (!o_valid && c < 50) begin
            @(posedge i_clk); #1;
            c++;
        end
        chk("clear_reach_emit", o_valid, 1);
        d0 = done_cnt;
        i_reg_clear = 1'b1;
        @(posedge i_clk); #1;
        i_reg_clear = 1'b0;
        chk("clear_idle", {o_busy, o_valid, o_mem_read_en, o_data, o_row_mask}, 0);
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("clear_no_done", done_cnt - d0, 0);

        run_job("basic_again", 0, 4, 2, 1, 0, 1);
`ifndef IM2COL_ROUTER_SKEW_EN
        chk("again_b0", {recv_dat[0], recv_msk[0]}, {32'h05040100, 4'hF});
        chk("again_b8", {recv_dat[8], recv_msk[8]}, {32'h0F0E0B0A, 4'hF});
`endif

        run_job("degenerate", 0, 4, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/im2col_router.md
Name: im2col_router

Overview:
Parametrised successor to the fixed 4-row input router. It generates its own output-pixel coordinates and walks a KxK convolution window for ROW_COUNT output pixels at a time. Elements are fetched through a single element-wide memory read port and presented as one ROW_COUNT-wide beat per kernel tap over a valid/ready handshake. It sits between the input feature-map buffer and the systolic array row inputs, and it handles tail groups and backpressure, which the previous router lacked.

Parameters:
ROW_COUNT, 4, output rows (output pixels processed in parallel per group)
DATA_WIDTH, 8, element width
ADDR_WIDTH, 8, memory element address width
DIM_WIDTH, 8, width of size/stride/coordinate values
KERNEL_SIZE, 3, square kernel edge K (taps per group = K*K)

Ports:
i_clk  input  1  clock
i_nrst  input  1  asynchronous active-low reset
i_en  input  1  start pulse; sampled only in IDLE
i_reg_clear  input  1  synchronous clear to IDLE
i_start_addr  input  ADDR_WIDTH  address of input element (0,0)
i_i_size  input  DIM_WIDTH  input feature-map edge
i_o_size  input  DIM_WIDTH  output feature-map edge
i_stride  input  DIM_WIDTH  convolution stride (>=1)
o_mem_read_en  output  1  memory read strobe
o_mem_read_addr  output  ADDR_WIDTH  memory read address
i_mem_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after strobe
o_data  output  ROW_COUNT*DATA_WIDTH  beat; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
o_row_mask  output  ROW_COUNT  per-row valid, bit r = row r
o_valid  output  1  beat valid
i_ready  input  1  consumer accepts beat
o_busy  output  1  high outside IDLE
o_done  output  1  one-cycle pulse at job end

Behaviour:
- Clocking/reset: single clock i_clk; reset i_nrst is asynchronous and active-low.
- Reset / i_reg_clear: state IDLE, all counters 0, all outputs 0. i_reg_clear wins over every other event. Reset mid-job abandons the job with no o_done.
- Config latch: all config is captured on the IDLE cycle with i_en=1. i_en is ignored while busy.
- Pixel ordering: pixel index p = g*ROW_COUNT + r. ox = p mod o_size, oy = p div o_size. Total P = o_size^2. Groups G = ceil(P/ROW_COUNT).
- Tap ordering: ky outer, kx inner, k = ky*K + kx.
- Address: addr = start_addr + (oy*stride+ky)*i_size + (ox*stride+kx), truncated mod 2^ADDR_WIDTH. Coordinates are walked incrementally; no divider.
- States: IDLE, FETCH, LAST, EMIT, DONE.
  - IDLE -> FETCH on i_en.
  - FETCH: one cycle per row r=0..ROW_COUNT-1. Rows with p < P issue o_mem_read_en with the address above. Rows with p >= P issue no read, their slot is zeroed and their mask bit is 0.
  - LAST: captures the final returned datum (1-cycle read latency).
  - EMIT: o_valid=1 with o_data and o_row_mask held stable until i_ready=1.
  - On accept: next tap -> FETCH; last tap of a non-final group -> next group, k=0 -> FETCH; last tap of the final group -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Timing: i_en at cycle 0 -> first read at cycle 1 -> first o_valid at cycle ROW_COUNT+2. With i_ready held high, one beat per ROW_COUNT+2 cycles.
- Outputs: o_valid drops the cycle after acceptance. Total beats = G*K*K. o_data is zero outside EMIT.
- Degenerate job: o_size=0 -> IDLE -> DONE directly, no beats.

Optional Feature:
IM2COL_ROUTER_SKEW_EN
- Defined:
  - Output path adds a per-row delay line of depth r (row 0 undelayed), advanced only on accepted beats, giving systolic skew. Data and mask are both delayed.
  - Delay lines start zero-filled. Skewed slots carry data 0 and mask 0.
  - After the last real beat, ROW_COUNT-1 flush beats (zero input) are emitted before DONE.
  - Total beats = G*K*K + ROW_COUNT-1.
- Undefined: no skew or flush; beats are exactly as above.

Test Plan:
- Basic: ROW_COUNT=4, K=3, mem[a]=a, start=0, i_size=4, o_size=2, stride=1, ready high. Beat0 rows {0,1,4,5}, mask 1111; beat8 rows {10,11,14,15}; 9 beats; o_done one cycle after beat8 is accepted; first o_valid at cycle 6.
- Stride: i_size=5, o_size=2, stride=2. Beat4 (ky=1,kx=1) rows {6,8,16,18}, mask 1111.
- Tail: i_size=5, o_size=3, stride=1. 27 beats; group 2 beat0 rows {12,0,0,0}, mask 0001, with exactly one read issued during that fetch.
- Backpressure: basic config, i_ready low for 5 cycles during beat3. o_valid stays high, o_data/o_row_mask stay stable, no extra reads, beat order unchanged.
- Reset/clear:
  - i_nrst low mid-FETCH: all outputs 0 immediately, no o_done.
  - i_reg_clear mid-EMIT: IDLE next cycle.
  - A new i_en then reproduces the basic result.
- SKEW_EN: basic config. 12 beats; beat0 rows {0,0,0,0} mask 0001; beat1 row1=1; beat11 row3=15, mask 1000.
